// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: boots the byte-wide instruction memory from a word loader,
// then drives the fetch PC (sequential / branch / jump / stall / halt).
//
// Loader handshake: a word transfers on a rising clk edge where ld_valid and
// ld_ready are both high. ld_data and ld_last are sampled only on that edge.
// ld_ready is high only while the sequencer is in LOAD. The sequencer never
// stalls a word it has accepted; each word takes one handshake cycle plus four
// byte-write cycles.
module imem_fetch_ctrl #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic [31:0]       I_mem_addr,
  input  logic [31:0]       IR,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [15:0]       br_offset,
  input  logic              jmp,
  input  logic [25:0]       jmp_target,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [31:0]       pc_plus4,
  output logic              halted
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [1:0]        byte_cnt;
  logic [31:0]       word_q;
  logic              last_q;
  logic [31:0]       pc;

  logic [ADDR_W-1:0] ptr_next;
  logic [1:0]        cnt_next;
  logic [31:0]       br_ext;
  logic [31:0]       next_pc;
  logic              next_oob;

  // Status outputs are plain decodes of the registered state.
  assign ld_ready    = (state == ST_LOAD);
  assign instr_valid = (state == ST_RUN);
  assign halted      = (state == ST_HALT);
  assign I_mem_addr  = pc;
  assign pc_plus4    = pc + 32'd4;
  assign instr       = IR;

  // Write-pointer and byte-lane bookkeeping for the current word.
  assign ptr_next = wr_ptr + ADDR_W'(4);
  assign cnt_next = byte_cnt + 2'd1;

  // Next-PC selection (jump beats branch) and the memory-range check.
  always_comb begin
    br_ext = {{14{br_offset[15]}}, br_offset, 2'b00};
    if (jmp) begin
      next_pc = {pc_plus4[31:28], jmp_target, 2'b00};
    end else if (br_taken) begin
      next_pc = pc_plus4 + br_ext;
    end else begin
      next_pc = pc_plus4;
    end
    next_oob = (next_pc[1:0] != 2'b00) || ((next_pc >> ADDR_W) != 32'd0);
  end

  // Sequencer: load words, spill them bytewise little-endian, then fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_LOAD;
      pc        <= RESET_PC;
      wr_ptr    <= '0;
      byte_cnt  <= 2'd0;
      word_q    <= 32'd0;
      last_q    <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= 8'd0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (ld_valid) begin
            word_q    <= ld_data;
            last_q    <= ld_last;
            byte_cnt  <= 2'd0;
            mem_we    <= 1'b1;
            mem_waddr <= wr_ptr;
            mem_wdata <= ld_data[7:0];
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (byte_cnt == 2'd3) begin
            mem_we   <= 1'b0;
            wr_ptr   <= ptr_next;
            byte_cnt <= 2'd0;
            pc       <= RESET_PC;
            // A wrapped pointer means the memory is full, so boot anyway.
            if (last_q || (ptr_next == '0)) begin
              state <= ST_RUN;
            end else begin
              state <= ST_LOAD;
            end
          end else begin
            byte_cnt  <= cnt_next;
            mem_waddr <= wr_ptr + ADDR_W'(cnt_next);
            mem_wdata <= word_q[{cnt_next, 3'b000} +: 8];
          end
        end
        ST_RUN: begin
          if (!stall) begin
            if (next_oob) begin
              state <= ST_HALT;
            end else begin
              pc <= next_pc;
            end
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed and randomized checks of the loader spill and
// the fetch sequencer against a bench-side memory and PC model.
module tb_imem_fetch_ctrl;

  localparam int AW  = 6;
  localparam int MSZ = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_valid = 1'b0;
  logic [31:0]   ld_data = 32'd0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [31:0]   I_mem_addr;
  logic [31:0]   IR;
  logic          stall = 1'b0;
  logic          br_taken = 1'b0;
  logic [15:0]   br_offset = 16'd0;
  logic          jmp = 1'b0;
  logic [25:0]   jmp_target = 26'd0;
  logic [31:0]   instr;
  logic          instr_valid;
  logic [31:0]   pc_plus4;
  logic          halted;

  imem_fetch_ctrl #(.ADDR_W(AW), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .I_mem_addr(I_mem_addr), .IR(IR),
    .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
    .jmp(jmp), .jmp_target(jmp_target),
    .instr(instr), .instr_valid(instr_valid), .pc_plus4(pc_plus4), .halted(halted)
  );

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  logic [7:0] mem [MSZ];
  logic       init_mem = 1'b1;
  logic [5:0] ra;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < MSZ; i++) mem[i] <= 8'((i * 37 + 5) & 255);
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    ra = I_mem_addr[5:0];
    IR = {mem[ra + 6'd3], mem[ra + 6'd2], mem[ra + 6'd1], mem[ra]};
  end

  // ---------------- scoreboard / model state ----------------
  logic [AW+7:0] exp_q[$];
  logic [7:0]    exp_mem [MSZ];
  int            n_cmp = 0;
  int            n_err = 0;
  int            ptr_m = 0;
  logic [31:0]   pc_m = 32'd0;
  bit            halt_m = 1'b0;
  int            run_cycles = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    int b;
    b = int'(a % MSZ);
    return {exp_mem[(b + 3) % MSZ], exp_mem[(b + 2) % MSZ],
            exp_mem[(b + 1) % MSZ], exp_mem[b]};
  endfunction

  // One byte-write cycle: pop the expected (addr,data) and compare.
  task automatic chk_write();
    logic [AW+7:0] e;
    chk("mem_we_write", {31'd0, mem_we}, 32'd1);
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("mem_waddr", {26'd0, mem_waddr}, {26'd0, e[AW+7:8]});
      chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e[7:0]});
      exp_mem[e[AW+7:8]] = e[7:0];
    end
  endtask

  // Push one loader word and check its four byte writes and the exit state.
  task automatic send_word(input logic [31:0] w, input logic last);
    bit exp_run;
    chk("ld_ready_load", {31'd0, ld_ready}, 32'd1);
    ld_valid = 1'b1;
    ld_data  = w;
    ld_last  = last;
    for (int k = 0; k < 4; k++)
      exp_q.push_back({6'((ptr_m + k) % MSZ), w[8*k +: 8]});
    tick();
    // Garbage on the loader while writing must be ignored.
    ld_valid = 1'($urandom_range(0, 1));
    ld_data  = $urandom;
    ld_last  = 1'($urandom_range(0, 1));
    for (int k = 0; k < 4; k++) begin
      chk("ld_ready_write", {31'd0, ld_ready}, 32'd0);
      chk_write();
      tick();
      if (k == 3) ld_valid = 1'b0;
    end
    ptr_m   = (ptr_m + 4) % MSZ;
    exp_run = last || (ptr_m == 0);
    chk("mem_we_after", {31'd0, mem_we}, 32'd0);
    chk("ld_ready_after", {31'd0, ld_ready}, {31'd0, !exp_run});
    chk("instr_valid_after", {31'd0, instr_valid}, {31'd0, exp_run});
    chk("pc_after_load", I_mem_addr, 32'd0);
    if (exp_run) begin
      chk("instr_boot", instr, exp_word(32'd0));
      pc_m   = 32'd0;
      halt_m = 1'b0;
    end
  endtask

  // One fetch cycle: drive controls, advance the model, compare.
  task automatic run_cycle(input bit s, input bit b, input int off, input bit j, input int tgt);
    logic [31:0] n;
    stall      = s;
    br_taken   = b;
    br_offset  = 16'(off);
    jmp        = j;
    jmp_target = 26'(tgt);
    if (!halt_m && !s) begin
      if (j)      n = ((pc_m + 32'd4) & 32'hF000_0000) | (32'(tgt) * 32'd4);
      else if (b) n = pc_m + 32'd4 + 32'(off * 4);
      else        n = pc_m + 32'd4;
      if (n >= 32'(MSZ) || (n % 4) != 0) halt_m = 1'b1;
      else pc_m = n;
    end
    tick();
    chk("pc", I_mem_addr, pc_m);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, !halt_m});
    chk("halted", {31'd0, halted}, {31'd0, halt_m});
    chk("instr", instr, exp_word(pc_m));
    chk("pc_plus4", pc_plus4, pc_m + 32'd4);
    chk("mem_we_run", {31'd0, mem_we}, 32'd0);
  endtask

  task automatic run_random();
    run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              int'($urandom_range(0, 12)) - 6, $urandom_range(0, 7) == 0,
              int'($urandom_range(0, 16)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ld_valid = 1'b0;
    stall = 1'b0; br_taken = 1'b0; jmp = 1'b0;
    ptr_m = 0; pc_m = 32'd0; halt_m = 1'b0;
    exp_q.delete();
  endtask

  task automatic load_random(input int last_idx);
    for (int i = 0; i < 16; i++) begin
      send_word($urandom, i == last_idx);
      if (i == last_idx) break;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < MSZ; i++) exp_mem[i] = 8'((i * 37 + 5) & 255);
    tick();
    init_mem = 1'b0;
    tick();
    // Reset state
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_waddr", {26'd0, mem_waddr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", I_mem_addr, 32'd0);
    rst = 1'b0;
    tick();

    // Three-word program, last flagged on the third
    send_word(32'h0022_1820, 1'b0);
    send_word(32'h2087_0080, 1'b0);
    send_word(32'h0800_0000, 1'b1);
    chk("boot_instr_literal", instr, 32'h0022_1820);
    chk("byte0_literal", {24'd0, mem[0]}, 32'h20);

    // Sequential, stall, jump, branch back, jump-over-branch, halt
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0, 0);
    chk("seq_pc12", I_mem_addr, 32'd12);
    run_cycle(1, 1, 5, 1, 3);
    run_cycle(1, 0, 0, 1, 9);
    chk("stall_pc12", I_mem_addr, 32'd12);
    run_cycle(0, 0, 0, 1, 2);
    chk("jmp_pc8", I_mem_addr, 32'd8);
    run_cycle(0, 1, -2, 0, 0);
    chk("br_pc4", I_mem_addr, 32'd4);
    run_cycle(0, 1, 3, 1, 15);
    chk("jmp_wins_pc60", I_mem_addr, 32'd60);
    run_cycle(0, 0, 0, 0, 0);
    chk("halt_pc60", I_mem_addr, 32'd60);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 3; i++) run_random();

    // Reset during the second byte of a write
    do_reset();
    ld_valid = 1'b1; ld_data = 32'hA1B2_C3D4; ld_last = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back({6'(k), ld_data[8*k +: 8]});
    tick();
    ld_valid = 1'b0;
    chk_write();
    tick();
    chk_write();
    rst = 1'b1;
    #1;
    chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("midrst_ld_ready", {31'd0, ld_ready}, 32'd1);
    tick();
    do_reset();
    send_word(32'h1357_9BDF, 1'b1);
    chk("after_midrst_instr", instr, 32'h1357_9BDF);

    // Sixteen words without last: wrap boots, a 17th word is refused
    do_reset();
    load_random(99);
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      run_cycle(1, 0, 0, 0, 0);
      chk("full_ld_ready", {31'd0, ld_ready}, 32'd0);
    end
    ld_valid = 1'b0;
    run_cycle(0, 1, 1, 0, 0);
    chk("br_plus1_pc8", I_mem_addr, 32'd8);

    // Randomized fetch control, reloading after each halt
    while (run_cycles < 400) begin
      if (halt_m) begin
        for (int i = 0; i < 2; i++) run_random();
        do_reset();
        load_random(int'($urandom_range(0, 20)));
      end
      run_random();
      run_cycles++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
